axi_s_mem_responder: RTL and testbench
======================================

AXI_S_MEM_RESPONDER -- requirements
Module: axi_s_mem_responder

Interface
REQ-001 SHALL have parameter AW_WIDTH, default 32, address width.
REQ-002 SHALL have parameter LEN, default 8, awlen/arlen width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width (8/16/32/64).
REQ-004 SHALL have parameter X, default 16, id/user width.
REQ-005 SHALL have parameter MEM_DEPTH, default 256, memory size in DATA_WIDTH words.
REQ-006 SHALL have ports (direction, width, meaning):
- axi_clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- awvalid/awaddr/awsize/awburst/awid/awlen  in  1/AW_WIDTH/3/2/X/LEN  write address.
- awready  out  1  write address accept.
- wvalid/wlast/wdata/wstrb  in  1/1/DATA_WIDTH/DATA_WIDTH/8  write data.
- wready  out  1  write data accept.
- bwvalid/bresp/bid/buser  out  1/2/X/X  write response.
- bwready  in  1  write response accept.
- arvalid/araddr/arsize/arburst/arid/arlen  in  1/AW_WIDTH/3/2/X/LEN  read address.
- aready  out  1  read address accept.
- rvalid/rlast/rdata/rid/ruser/rresp  out  1/1/DATA_WIDTH/X/X/2  read data.
- rready  in  1  read data accept.
- awcache, awprot, awlock, awqos, awregion, awuser, wid, wuser, arcache, arprot, arlock, arqos, aregion, aruser  in  per bus widths  accepted and ignored.

Function
REQ-007 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; read FSM R_IDLE, R_DATA; both SHALL run independently and concurrently.
REQ-008 awready SHALL be 1 only in W_IDLE; on awvalid&awready, SHALL capture id/addr/len/size/burst and enter W_DATA the next cycle.
REQ-009 wready SHALL be 1 only in W_DATA; each wvalid&wready beat SHALL write the bytes enabled by wstrb into word index = addr >> log2(DATA_WIDTH/8).
REQ-010 Next beat address SHALL be addr + 2^size for INCR and unchanged for FIXED, computed modulo 2^AW_WIDTH.
REQ-011 The write burst SHALL end on the beat with wlast=1, moving to W_RESP; bwvalid SHALL assert the following cycle and hold until bwready, then return to W_IDLE.
REQ-012 bid SHALL equal captured awid; buser SHALL be 0.
REQ-013 bresp SHALL be SLVERR (2'b10) if any of: burst=WRAP or reserved, 2^size > DATA_WIDTH/8, any beat word index >= MEM_DEPTH, beat count != awlen+1; otherwise OKAY (2'b00).
REQ-014 Beats that are out of range, or in a WRAP/reserved/oversize burst, SHALL NOT modify memory; other beats of an erroneous burst SHALL still be written.
REQ-015 aready SHALL be 1 only in R_IDLE; on arvalid&aready, SHALL capture request and present beat 0 with rvalid=1 on the next cycle (1-cycle latency).
REQ-016 rdata/rresp/rlast SHALL be registered and held stable while rvalid&!rready.
REQ-017 On rvalid&rready of a non-last beat, the next beat SHALL be presented the following cycle (full throughput with rready held high).
REQ-018 rlast SHALL be 1 exactly on beat arlen; after its handshake, FSM SHALL return to R_IDLE and rvalid SHALL drop.
REQ-019 rresp SHALL be SLVERR per beat when the beat is out of range, burst is WRAP/reserved, or size oversize; rdata SHALL then be 0; rid = arid, ruser = 0.
REQ-020 Read and write of the same word in the same cycle SHALL return old data (read-before-write).
REQ-021 awlen/arlen = 0 SHALL be a valid single-beat burst; maximum burst 2^LEN beats.

Reset
REQ-022 While rst=0, FSMs SHALL be W_IDLE/R_IDLE and all outputs 0; awready and aready SHALL go 1 on the first rising edge after rst deasserts.
REQ-023 Reset mid-burst SHALL abandon the burst without a response; memory contents SHALL NOT be reset.

Structure
REQ-024 Package axi_s_pkg SHALL hold resp constants (OKAY, SLVERR), burst type enum (FIXED, INCR, WRAP), and FSM state enums.
REQ-025 Sub-module axi_s_burst_addr SHALL compute next address, word index and range/legality error; instantiated once per channel.

Verification
REQ-026 INCR write awaddr=0x10, awlen=3, size=2, data 1..4, wstrb=0xF -> bresp OKAY, bid=awid; INCR read of same -> rdata 1,2,3,4, rlast on 4th beat only.
REQ-027 Read with rready toggling 1/0 each cycle -> rdata/rlast stable while stalled, 4 beats in 8 cycles, no beat lost or duplicated.
REQ-028 Write awaddr=0x3FC, awlen=1 (second beat at word 256) -> word 255 written, word 256 not, bresp SLVERR.
REQ-029 WRAP burst write, and write with wlast on beat 1 of awlen=3 -> both bresp SLVERR; WRAP leaves memory unchanged.
REQ-030 FIXED write awlen=2 to 0x20 with data A,B,C and wstrb 0x1,0x2,0x4 -> read word 8 returns byte lanes C,B,A merged.
REQ-031 rst pulled low mid write burst and mid read burst -> bwvalid=rvalid=0 immediately; awready/aready=1 one edge after release; prior memory data intact.

Source files
------------

// File: rtl/axi_s_pkg.sv
// Shared types and constants for the AXI memory responder.
package axi_s_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

endpackage

// File: rtl/axi_s_burst_addr.sv
// Per-beat address helper: next beat address, memory word index and beat legality.
module axi_s_burst_addr
    import axi_s_pkg::*;
#(
    parameter int AW_WIDTH   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic [AW_WIDTH-1:0] addr,
    input  logic [2:0]          size,
    input  logic [1:0]          burst,
    output logic [AW_WIDTH-1:0] next_addr,
    output logic [IDX_W-1:0]    word_idx,
    output logic                err
);

    localparam int BYTE_LG = $clog2(DATA_WIDTH / 8);

    logic [AW_WIDTH-1:0] full_idx;
    logic                bad_burst;
    logic                bad_size;
    logic                bad_range;

    // Decode the current beat: word index, range/legality flags and the following beat address
    always_comb begin
        full_idx  = addr >> BYTE_LG;
        word_idx  = full_idx[IDX_W-1:0];
        bad_burst = (burst != INCR) && (burst != FIXED);
        bad_size  = int'(size) > BYTE_LG;
        bad_range = full_idx >= AW_WIDTH'(MEM_DEPTH);
        err       = bad_burst || bad_size || bad_range;
        next_addr = (burst == INCR) ? addr + (AW_WIDTH'(1) << size) : addr;
    end

endmodule

// File: rtl/axi_s_mem_responder.sv
// AXI slave backed by a word-addressed memory; independent write and read channels.
module axi_s_mem_responder
    import axi_s_pkg::*;
#(
    parameter int AW_WIDTH   = 32,
    parameter int LEN        = 8,
    parameter int DATA_WIDTH = 32,
    parameter int X          = 16,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                    axi_clk,
    input  logic                    rst,
    // write address
    input  logic                    awvalid,
    input  logic [AW_WIDTH-1:0]     awaddr,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic [X-1:0]            awid,
    input  logic [LEN-1:0]          awlen,
    output logic                    awready,
    input  logic [3:0]              awcache,
    input  logic [2:0]              awprot,
    input  logic                    awlock,
    input  logic [3:0]              awqos,
    input  logic [3:0]              awregion,
    input  logic [X-1:0]            awuser,
    // write data
    input  logic                    wvalid,
    input  logic                    wlast,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wready,
    input  logic [X-1:0]            wid,
    input  logic [X-1:0]            wuser,
    // write response
    output logic                    bwvalid,
    output logic [1:0]              bresp,
    output logic [X-1:0]            bid,
    output logic [X-1:0]            buser,
    input  logic                    bwready,
    // read address
    input  logic                    arvalid,
    input  logic [AW_WIDTH-1:0]     araddr,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic [X-1:0]            arid,
    input  logic [LEN-1:0]          arlen,
    output logic                    aready,
    input  logic [3:0]              arcache,
    input  logic [2:0]              arprot,
    input  logic                    arlock,
    input  logic [3:0]              arqos,
    input  logic [3:0]              aregion,
    input  logic [X-1:0]            aruser,
    // read data
    output logic                    rvalid,
    output logic                    rlast,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [X-1:0]            rid,
    output logic [X-1:0]            ruser,
    output logic [1:0]              rresp,
    input  logic                    rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  rst_done;

    w_state_e              w_state_q, w_state_d;
    logic [AW_WIDTH-1:0]   w_addr, w_next;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic [X-1:0]          w_id;
    logic [LEN-1:0]        w_len, w_cnt;
    logic                  w_err, w_beat, w_beat_err, w_len_bad;
    logic [1:0]            w_resp;
    logic [IDX_W-1:0]      w_idx;

    r_state_e              r_state_q, r_state_d;
    logic [AW_WIDTH-1:0]   r_addr, r_in_addr, r_next;
    logic [2:0]            r_size, r_in_size;
    logic [1:0]            r_burst, r_in_burst;
    logic [X-1:0]          r_id;
    logic [LEN-1:0]        r_len, r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_beat_err, r_load_first, r_load_next;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;

    logic                  unused_inputs;

    // Sideband inputs carry no meaning for this responder
    always_comb begin
        unused_inputs = ^{awcache, awprot, awlock, awqos, awregion, awuser, wid, wuser,
                          arcache, arprot, arlock, arqos, aregion, aruser};
    end

    axi_s_burst_addr #(
        .AW_WIDTH  (AW_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_w_addr (
        .addr     (w_addr),
        .size     (w_size),
        .burst    (w_burst),
        .next_addr(w_next),
        .word_idx (w_idx),
        .err      (w_beat_err)
    );

    axi_s_burst_addr #(
        .AW_WIDTH  (AW_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_r_addr (
        .addr     (r_in_addr),
        .size     (r_in_size),
        .burst    (r_in_burst),
        .next_addr(r_next),
        .word_idx (r_idx),
        .err      (r_beat_err)
    );

    // Ready outputs stay low through reset and rise on the first edge afterwards
    always_ff @(posedge axi_clk or negedge rst) begin
        if (!rst) rst_done <= 1'b0;
        else      rst_done <= 1'b1;
    end

    // Output decode and handshake qualifiers
    always_comb begin
        awready      = rst_done && (w_state_q == W_IDLE);
        wready       = (w_state_q == W_DATA);
        bwvalid      = (w_state_q == W_RESP);
        bresp        = bwvalid ? w_resp : OKAY;
        bid          = bwvalid ? w_id : '0;
        buser        = '0;
        aready       = rst_done && (r_state_q == R_IDLE);
        rvalid       = (r_state_q == R_DATA);
        rdata        = rdata_q;
        rresp        = rresp_q;
        rlast        = rlast_q;
        rid          = r_id;
        ruser        = '0;
        w_beat       = wvalid && wready;
        // a last beat must land on awlen; a non-last beat at awlen means too many beats
        w_len_bad    = wlast ? (w_cnt != w_len) : (w_cnt == w_len);
        r_in_addr    = (r_state_q == R_IDLE) ? araddr  : r_addr;
        r_in_size    = (r_state_q == R_IDLE) ? arsize  : r_size;
        r_in_burst   = (r_state_q == R_IDLE) ? arburst : r_burst;
        r_load_first = arvalid && aready;
        r_load_next  = rvalid && rready && !rlast_q;
    end

    // Write FSM state register
    always_ff @(posedge axi_clk or negedge rst) begin
        if (!rst) w_state_q <= W_IDLE;
        else      w_state_q <= w_state_d;
    end

    // Write FSM next state
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (awvalid && awready) w_state_d = W_DATA;
            W_DATA:  if (w_beat && wlast)    w_state_d = W_RESP;
            W_RESP:  if (bwready)            w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write request capture, per-beat address stepping and error accumulation
    always_ff @(posedge axi_clk or negedge rst) begin
        if (!rst) begin
            w_addr  <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_id    <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            w_resp  <= OKAY;
        end else begin
            if (awvalid && awready) begin
                w_addr  <= awaddr;
                w_size  <= awsize;
                w_burst <= awburst;
                w_id    <= awid;
                w_len   <= awlen;
                w_cnt   <= '0;
                w_err   <= 1'b0;
            end
            if (w_beat) begin
                w_addr <= w_next;
                w_cnt  <= w_cnt + LEN'(1);
                w_err  <= w_err || w_beat_err || w_len_bad;
                if (wlast) w_resp <= (w_err || w_beat_err || w_len_bad) ? SLVERR : OKAY;
            end
        end
    end

    // Byte-lane memory update for each legal write beat; contents survive reset
    always_ff @(posedge axi_clk) begin
        if (w_beat && !w_beat_err) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge axi_clk or negedge rst) begin
        if (!rst) r_state_q <= R_IDLE;
        else      r_state_q <= r_state_d;
    end

    // Read FSM next state
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (r_load_first)              r_state_d = R_DATA;
            R_DATA:  if (rvalid && rready && rlast_q) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read beat registers: load beat 0 on address accept, next beat on each non-last handshake
    always_ff @(posedge axi_clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            rdata_q <= '0;
            rresp_q <= OKAY;
            rlast_q <= 1'b0;
        end else if (r_load_first || r_load_next) begin
            r_addr  <= r_next;
            rdata_q <= r_beat_err ? '0 : mem[r_idx];
            rresp_q <= r_beat_err ? SLVERR : OKAY;
            if (r_load_first) begin
                r_size  <= arsize;
                r_burst <= arburst;
                r_id    <= arid;
                r_len   <= arlen;
                r_cnt   <= '0;
                rlast_q <= (arlen == '0);
            end else begin
                r_cnt   <= r_cnt + LEN'(1);
                rlast_q <= ((r_cnt + LEN'(1)) == r_len);
            end
        end
    end

endmodule

// File: tb/tb_axi_s_mem_responder.sv
// Directed bench for axi_s_mem_responder: vector table plus multi-cycle burst sequences.
module tb_axi_s_mem_responder;
    import axi_s_pkg::*;

    localparam int AW = 32, L = 8, DW = 32, XW = 16, DEPTH = 256;

    logic          axi_clk = 1'b0;
    logic          rst = 1'b0;
    logic          awvalid = 0, awready;
    logic [AW-1:0] awaddr = '0;
    logic [2:0]    awsize = '0;
    logic [1:0]    awburst = '0;
    logic [XW-1:0] awid = '0;
    logic [L-1:0]  awlen = '0;
    logic          wvalid = 0, wlast = 0, wready;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          bwvalid, bwready = 0;
    logic [1:0]    bresp;
    logic [XW-1:0] bid, buser;
    logic          arvalid = 0, aready;
    logic [AW-1:0] araddr = '0;
    logic [2:0]    arsize = '0;
    logic [1:0]    arburst = '0;
    logic [XW-1:0] arid = '0;
    logic [L-1:0]  arlen = '0;
    logic          rvalid, rlast, rready = 0;
    logic [DW-1:0] rdata;
    logic [XW-1:0] rid, ruser;
    logic [1:0]    rresp;

    axi_s_mem_responder #(
        .AW_WIDTH(AW), .LEN(L), .DATA_WIDTH(DW), .X(XW), .MEM_DEPTH(DEPTH)
    ) dut (
        .axi_clk(axi_clk), .rst(rst),
        .awvalid(awvalid), .awaddr(awaddr), .awsize(awsize), .awburst(awburst),
        .awid(awid), .awlen(awlen), .awready(awready),
        .awcache(4'd0), .awprot(3'd0), .awlock(1'b0), .awqos(4'd0), .awregion(4'd0), .awuser(16'd0),
        .wvalid(wvalid), .wlast(wlast), .wdata(wdata), .wstrb(wstrb), .wready(wready),
        .wid(16'd0), .wuser(16'd0),
        .bwvalid(bwvalid), .bresp(bresp), .bid(bid), .buser(buser), .bwready(bwready),
        .arvalid(arvalid), .araddr(araddr), .arsize(arsize), .arburst(arburst),
        .arid(arid), .arlen(arlen), .aready(aready),
        .arcache(4'd0), .arprot(3'd0), .arlock(1'b0), .arqos(4'd0), .aregion(4'd0), .aruser(16'd0),
        .rvalid(rvalid), .rlast(rlast), .rdata(rdata), .rid(rid), .ruser(ruser), .rresp(rresp),
        .rready(rready)
    );

    always #5 axi_clk = ~axi_clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] wd [16];
    logic [3:0]    ws [16];
    logic [DW-1:0] rd_d [64];
    logic [1:0]    rd_r [64];
    logic          rd_l [64];
    logic [XW-1:0] rd_id;
    int            rd_n, rd_first, rd_span;
    logic [1:0]    b_resp;
    logic [XW-1:0] b_id;

    typedef struct {
        logic [AW-1:0] addr;
        logic [2:0]    size;
        logic [1:0]    burst;
        logic [DW-1:0] wdata;
        logic [3:0]    wstrb;
        logic [1:0]    exp_b;
        logic [DW-1:0] exp_rd;
        logic [1:0]    exp_rr;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake did not occur, expected within bound", name);
    endtask

    task automatic aw_phase(input logic [AW-1:0] a, input logic [L-1:0] len, input logic [2:0] sz,
                            input logic [1:0] bu, input logic [XW-1:0] id);
        int n = 0;
        @(negedge axi_clk);
        awvalid = 1; awaddr = a; awlen = len; awsize = sz; awburst = bu; awid = id;
        while (!awready && n < 50) begin @(negedge axi_clk); n++; end
        if (!awready) timeout_fail("aw_accept");
        @(posedge axi_clk); #1 awvalid = 0;
    endtask

    task automatic w_beats(input int nbeats, input int last_at);
        for (int i = 0; i < nbeats; i++) begin
            int n = 0;
            @(negedge axi_clk);
            wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_at);
            while (!wready && n < 50) begin @(negedge axi_clk); n++; end
            if (!wready) timeout_fail("w_accept");
            @(posedge axi_clk); #1 wvalid = 0; wlast = 0;
        end
    endtask

    task automatic b_phase();
        int n = 0;
        @(negedge axi_clk);
        while (!bwvalid && n < 50) begin @(negedge axi_clk); n++; end
        if (!bwvalid) timeout_fail("b_valid");
        b_resp = bresp; b_id = bid; bwready = 1;
        @(posedge axi_clk); #1 bwready = 0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [L-1:0] len, input logic [2:0] sz,
                            input logic [1:0] bu, input logic [XW-1:0] id,
                            input int nbeats, input int last_at);
        aw_phase(a, len, sz, bu, id);
        w_beats(nbeats, last_at);
        b_phase();
    endtask

    task automatic ar_phase(input logic [AW-1:0] a, input logic [L-1:0] len, input logic [2:0] sz,
                            input logic [1:0] bu, input logic [XW-1:0] id);
        int n = 0;
        @(negedge axi_clk);
        arvalid = 1; araddr = a; arlen = len; arsize = sz; arburst = bu; arid = id;
        while (!aready && n < 50) begin @(negedge axi_clk); n++; end
        if (!aready) timeout_fail("ar_accept");
        @(posedge axi_clk); #1 arvalid = 0;
    endtask

    // rready held high; records every beat and where it appeared
    task automatic r_collect(input int max_beats);
        int  n = 0;
        bit  done = 0;
        rd_n = 0; rd_first = -1; rd_span = 0;
        @(negedge axi_clk);
        rready = 1;
        while (!done && n < 300) begin
            if (rvalid) begin
                if (rd_first < 0) rd_first = n;
                rd_d[rd_n] = rdata; rd_r[rd_n] = rresp; rd_l[rd_n] = rlast; rd_id = rid;
                rd_n++;
                rd_span = n - rd_first + 1;
                if (rlast || rd_n >= max_beats) done = 1;
            end
            if (!done) begin @(negedge axi_clk); n++; end
        end
        if (!done) timeout_fail("r_beats");
        @(posedge axi_clk); #1 rready = 0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [L-1:0] len, input logic [2:0] sz,
                           input logic [1:0] bu, input logic [XW-1:0] id);
        ar_phase(a, len, sz, bu, id);
        r_collect(64);
    endtask

    initial begin
        logic          stalled;
        logic [DW-1:0] sd;
        logic          sl;

        vecs[0] = '{32'h80,    3'd2, INCR,  32'hA5A5A5A5, 4'hF, OKAY,   32'hA5A5A5A5, OKAY};
        vecs[1] = '{32'h84,    3'd2, INCR,  32'h12345678, 4'h3, OKAY,   32'h00005678, OKAY};
        vecs[2] = '{32'h88,    3'd2, FIXED, 32'hFFEEDDCC, 4'hC, OKAY,   32'hFFEE0000, OKAY};
        vecs[3] = '{32'h8C,    3'd3, INCR,  32'h11111111, 4'hF, SLVERR, 32'h00000000, OKAY};
        vecs[4] = '{32'h90,    3'd2, 2'b11, 32'h22222222, 4'hF, SLVERR, 32'h00000000, OKAY};
        vecs[5] = '{32'h94,    3'd0, INCR,  32'h000000AB, 4'h1, OKAY,   32'h000000AB, OKAY};
        vecs[6] = '{32'h400,   3'd2, INCR,  32'h33333333, 4'hF, SLVERR, 32'h00000000, SLVERR};
        vecs[7] = '{32'h3F8,   3'd2, INCR,  32'h00000077, 4'hF, OKAY,   32'h00000077, OKAY};
        vecs[8] = '{32'h10000, 3'd2, INCR,  32'h44444444, 4'hF, SLVERR, 32'h00000000, SLVERR};

        // reset state
        repeat (2) @(negedge axi_clk);
        chk("rst_awready", awready, 0);
        chk("rst_aready", aready, 0);
        chk("rst_bwvalid", bwvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_wready", wready, 0);
        rst = 1;
        #1 chk("rel_awready_before_edge", awready, 0);
        @(posedge axi_clk); #1;
        chk("rel_awready", awready, 1);
        chk("rel_aready", aready, 1);

        // INCR write 0x10 len 3 data 1..4 then read back at full throughput
        for (int i = 0; i < 4; i++) begin wd[i] = DW'(i + 1); ws[i] = 4'hF; end
        do_write(32'h10, 8'd3, 3'd2, INCR, 16'h1234, 4, 3);
        chk("incr_bresp", b_resp, OKAY);
        chk("incr_bid", b_id, 16'h1234);
        @(negedge axi_clk);
        chk("incr_bwvalid_drop", bwvalid, 0);
        do_read(32'h10, 8'd3, 3'd2, INCR, 16'h0ABC);
        chk("incr_rd_beats", rd_n, 4);
        chk("incr_rd_latency", rd_first, 0);
        chk("incr_rd_span", rd_span, 4);
        chk("incr_rid", rd_id, 16'h0ABC);
        for (int i = 0; i < 4; i++) begin
            chk("incr_rdata", rd_d[i], DW'(i + 1));
            chk("incr_rlast", rd_l[i], (i == 3));
            chk("incr_rresp", rd_r[i], OKAY);
        end
        @(negedge axi_clk);
        chk("incr_rvalid_drop", rvalid, 0);

        // rready toggling 1/0: stalled beats must hold, 4 beats inside 8 cycles
        ar_phase(32'h10, 8'd3, 3'd2, INCR, 16'h0001);
        rd_n = 0; stalled = 0; sd = '0; sl = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge axi_clk);
            if (stalled) begin
                chk("stall_rvalid", rvalid, 1);
                chk("stall_rdata", rdata, sd);
                chk("stall_rlast", rlast, sl);
            end
            rready = (c % 2 == 0);
            if (rvalid && rready && rd_n < 64) begin
                rd_d[rd_n] = rdata; rd_l[rd_n] = rlast; rd_n++;
            end
            stalled = rvalid && !rready;
            sd = rdata; sl = rlast;
        end
        rready = 0;
        chk("toggle_beats", rd_n, 4);
        for (int i = 0; i < 4; i++) begin
            chk("toggle_rdata", rd_d[i], DW'(i + 1));
            chk("toggle_rlast", rd_l[i], (i == 3));
        end
        chk("toggle_rvalid_end", rvalid, 0);

        // vector table: init 0x80..0x9C to zero, then single-beat write + read per record
        for (int i = 0; i < 8; i++) begin wd[i] = '0; ws[i] = 4'hF; end
        do_write(32'h80, 8'd7, 3'd2, INCR, 16'h0002, 8, 7);
        chk("init_bresp", b_resp, OKAY);
        for (int v = 0; v < 9; v++) begin
            wd[0] = vecs[v].wdata; ws[0] = vecs[v].wstrb;
            do_write(vecs[v].addr, 8'd0, vecs[v].size, vecs[v].burst, 16'(16'h0100 + v), 1, 0);
            chk($sformatf("vec%0d_bresp", v), b_resp, vecs[v].exp_b);
            chk($sformatf("vec%0d_bid", v), b_id, 16'(16'h0100 + v));
            do_read(vecs[v].addr, 8'd0, 3'd2, INCR, 16'h0200);
            chk($sformatf("vec%0d_rdata", v), rd_d[0], vecs[v].exp_rd);
            chk($sformatf("vec%0d_rresp", v), rd_r[0], vecs[v].exp_rr);
            chk($sformatf("vec%0d_rlast", v), rd_l[0], 1);
        end

        // burst crossing the top of memory: word 255 written, word 256 not
        wd[0] = 32'hAAAA0001; wd[1] = 32'hBBBB0002; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(32'h3FC, 8'd1, 3'd2, INCR, 16'h0003, 2, 1);
        chk("edge_bresp", b_resp, SLVERR);
        do_read(32'h3FC, 8'd1, 3'd2, INCR, 16'h0004);
        chk("edge_rd_beats", rd_n, 2);
        chk("edge_w255", rd_d[0], 32'hAAAA0001);
        chk("edge_w255_resp", rd_r[0], OKAY);
        chk("edge_w256", rd_d[1], 32'h0);
        chk("edge_w256_resp", rd_r[1], SLVERR);

        // WRAP write is refused and leaves memory untouched
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        do_write(32'h40, 8'd0, 3'd2, INCR, 16'h0005, 1, 0);
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h0BAD0000 + DW'(i); ws[i] = 4'hF; end
        do_write(32'h40, 8'd3, 3'd2, WRAP, 16'h0006, 4, 3);
        chk("wrap_bresp", b_resp, SLVERR);
        do_read(32'h40, 8'd0, 3'd2, INCR, 16'h0007);
        chk("wrap_mem", rd_d[0], 32'hCAFEF00D);

        // early wlast on beat 1 of awlen=3: error response, beats still land
        wd[0] = 32'h50500001; wd[1] = 32'h50500002; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(32'h50, 8'd3, 3'd2, INCR, 16'h0008, 2, 1);
        chk("short_bresp", b_resp, SLVERR);
        do_read(32'h50, 8'd1, 3'd2, INCR, 16'h0009);
        chk("short_beat0", rd_d[0], 32'h50500001);
        chk("short_beat1", rd_d[1], 32'h50500002);

        // FIXED burst merges byte lanes into one word
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(32'h20, 8'd0, 3'd2, INCR, 16'h000A, 1, 0);
        wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333;
        ws[0] = 4'h1; ws[1] = 4'h2; ws[2] = 4'h4;
        do_write(32'h20, 8'd2, 3'd2, FIXED, 16'h000B, 3, 2);
        chk("fixed_bresp", b_resp, OKAY);
        do_read(32'h20, 8'd0, 3'd2, INCR, 16'h000C);
        chk("fixed_merge", rd_d[0], 32'hDE332211);

        // reset in the middle of a write burst and a read burst
        wd[0] = 32'h77770000; ws[0] = 4'hF;
        aw_phase(32'hC0, 8'd3, 3'd2, INCR, 16'h000D);
        w_beats(1, 9);
        ar_phase(32'h10, 8'd3, 3'd2, INCR, 16'h000E);
        @(negedge axi_clk);
        chk("mid_rvalid", rvalid, 1);
        chk("mid_wready", wready, 1);
        rst = 0;
        #1;
        chk("mrst_bwvalid", bwvalid, 0);
        chk("mrst_rvalid", rvalid, 0);
        chk("mrst_awready", awready, 0);
        chk("mrst_aready", aready, 0);
        chk("mrst_wready", wready, 0);
        @(negedge axi_clk);
        rst = 1;
        #1 chk("mrel_awready_before_edge", awready, 0);
        @(posedge axi_clk); #1;
        chk("mrel_awready", awready, 1);
        chk("mrel_aready", aready, 1);
        chk("mrel_wready", wready, 0);
        do_read(32'h10, 8'd3, 3'd2, INCR, 16'h000F);
        chk("mrel_rd_beats", rd_n, 4);
        for (int i = 0; i < 4; i++) chk("mrel_mem_kept", rd_d[i], DW'(i + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global guard so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
